cu_regfile_sb: RTL and testbench

- Parametrised general-purpose register file with an integrated write scoreboard. It succeeds the flat register array inside the CU.
- Sits between the CU decode stage (issue side) and the writeback stage. Provides NRD combinational read ports with optional writeback bypass.
- Tracks which destination registers have outstanding writes. Holds off issue on RAW/WAW hazards, counts stall cycles, and flags scoreboard protocol errors.

---
 rtl/cu_pkg.sv | 19 +
 rtl/cu_scoreboard.sv | 73 +++++++
 rtl/cu_regfile_sb.sv | 82 ++++++++
 tb/tb_cu_regfile_sb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the CU register file: ABI register names and defaults.
package cu_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   localparam logic [XLEN_DEF-1:0] SP_INIT_DEF = 32'h0000_0200;

   // ABI register indices
   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;
   localparam int REG_GP   = 3;
   localparam int REG_TP   = 4;
   localparam int REG_T0   = 5;

   typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/cu_scoreboard.sv
// Write scoreboard: pending-write tracking, RAW/WAW hazard detection,
// stall-cycle counter and sticky protocol-error flag.
module cu_scoreboard
   import cu_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic             soc_clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [AW-1:0]    issue_rd,
   input  logic             issue_wr,
   input  logic [AW-1:0]    issue_rs1,
   input  logic [AW-1:0]    issue_rs2,
   input  logic             issue_use1,
   input  logic             issue_use2,
   output logic             issue_ready,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_addr,
   input  logic             flush,
   output logic [NREGS-1:0] pending,
   output logic [15:0]      stall_cnt,
   output logic             sb_err
);

   logic             clr1, clr2, wb_hits_rd;
   logic             raw1, raw2, waw;
   logic             accept, wb_live;
   logic [NREGS-1:0] pending_nxt;

   // Hazard detection; a same-cycle writeback releases RAW only when bypassing,
   // but always releases WAW since the write lands before the new one issues.
   always_comb begin
      clr1       = (BYPASS != 0) && wb_valid && (wb_addr == issue_rs1);
      clr2       = (BYPASS != 0) && wb_valid && (wb_addr == issue_rs2);
      wb_hits_rd = wb_valid && (wb_addr == issue_rd);
      raw1       = issue_use1 && (issue_rs1 != '0) && pending[issue_rs1] && !clr1;
      raw2       = issue_use2 && (issue_rs2 != '0) && pending[issue_rs2] && !clr2;
      waw        = issue_wr && (issue_rd != '0) && pending[issue_rd] && !wb_hits_rd;
      issue_ready = !reset && !flush && !raw1 && !raw2 && !waw;
      accept     = issue_valid && issue_ready;
      wb_live    = wb_valid && (wb_addr != '0);
   end

   // Next pending vector: writeback clears, accepted issue sets (set wins).
   always_comb begin
      pending_nxt = pending;
      if (wb_live) pending_nxt[wb_addr] = 1'b0;
      if (accept && issue_wr && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Pending register; reset and flush both wipe every outstanding write.
   always_ff @(posedge soc_clk) begin
      if (reset || flush) pending <= '0;
      else                pending <= pending_nxt;
   end

   // Sticky error on a writeback that no issue is waiting for.
   always_ff @(posedge soc_clk) begin
      if (reset)                                   sb_err <= 1'b0;
      else if (wb_live && !pending[wb_addr] && !flush) sb_err <= 1'b1;
   end

   // Saturating count of cycles in which decode was held off.
   always_ff @(posedge soc_clk) begin
      if (reset)                                             stall_cnt <= '0;
      else if (issue_valid && !issue_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: rtl/cu_regfile_sb.sv
// General-purpose register file with combinational read ports, optional
// writeback bypass and an attached write scoreboard.
module cu_regfile_sb
   import cu_pkg::*;
#(
   parameter int              XLEN    = XLEN_DEF,
   parameter int              NREGS   = NREGS_DEF,
   parameter int              NRD     = 2,
   parameter int              BYPASS  = 1,
   parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEF,
   parameter int              AW      = $clog2(NREGS)
) (
   input  logic                soc_clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   input  logic                issue_wr,
   input  logic [AW-1:0]       issue_rs1,
   input  logic [AW-1:0]       issue_rs2,
   input  logic                issue_use1,
   input  logic                issue_use2,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [AW-1:0]       wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush,
   output logic [NREGS-1:0]    pending,
   output logic [15:0]         stall_cnt,
   output logic                sb_err
);

   logic [XLEN-1:0] regs [NREGS];

   // Register array; reg 0 is never written so it stays zero after reset.
   always_ff @(posedge soc_clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end else if (wb_valid && wb_addr != '0) begin
         regs[wb_addr] <= wb_data;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[p*AW +: AW];
      // Read mux with writeback forwarding.
      always_comb begin
         if (ra == '0)
            rd_data[p*XLEN +: XLEN] = '0;
         else if ((BYPASS != 0) && wb_valid && (wb_addr == ra))
            rd_data[p*XLEN +: XLEN] = wb_data;
         else
            rd_data[p*XLEN +: XLEN] = regs[ra];
      end
   end

   cu_scoreboard #(
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_sb (
      .soc_clk     (soc_clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_wr    (issue_wr),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_use1  (issue_use1),
      .issue_use2  (issue_use2),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .flush       (flush),
      .pending     (pending),
      .stall_cnt   (stall_cnt),
      .sb_err      (sb_err)
   );

endmodule

// File: tb/tb_cu_regfile_sb.sv
// Scoreboard-style bench for cu_regfile_sb: the driver computes expected
// outputs from a behavioural model and queues them; a monitor compares them.
module tb_cu_regfile_sb;

   localparam int          XLEN = 32;
   localparam int          NREGS = 32;
   localparam int          AW = 5;
   localparam logic [31:0] SP = 32'h0000_0200;

   localparam int K_RD0 = 0, K_RD1 = 1, K_RDY = 2, K_PEND = 3, K_STALL = 4, K_ERR = 5;

   logic            soc_clk = 1'b0;
   logic            reset = 1'b1;
   logic [2*AW-1:0] rd_addr = '0;
   logic [63:0]     rd_data;
   logic            issue_valid = 1'b0, issue_wr = 1'b0, issue_use1 = 1'b0, issue_use2 = 1'b0;
   logic [AW-1:0]   issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
   logic            issue_ready;
   logic            wb_valid = 1'b0;
   logic [AW-1:0]   wb_addr = '0;
   logic [31:0]     wb_data = '0;
   logic            flush = 1'b0;
   logic [31:0]     pending;
   logic [15:0]     stall_cnt;
   logic            sb_err;

   cu_regfile_sb dut (
      .soc_clk(soc_clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use1(issue_use1),
      .issue_use2(issue_use2), .issue_ready(issue_ready), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .pending(pending),
      .stall_cnt(stall_cnt), .sb_err(sb_err)
   );

   always #5 soc_clk = ~soc_clk;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   cyc_count = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   chk_on = 1'b0;

   // Reference model: architectural state as plain arrays and integers.
   logic [31:0] m_reg [NREGS];
   bit          m_pend [NREGS];
   bit          m_err;
   int          m_stall;

   function automatic string kname(int k);
      case (k)
         K_RD0:   return "rd_data0";
         K_RD1:   return "rd_data1";
         K_RDY:   return "issue_ready";
         K_PEND:  return "pending";
         K_STALL: return "stall_cnt";
         default: return "sb_err";
      endcase
   endfunction

   function automatic logic [31:0] actual(int k);
      case (k)
         K_RD0:   return rd_data[31:0];
         K_RD1:   return rd_data[63:32];
         K_RDY:   return {31'b0, issue_ready};
         K_PEND:  return pending;
         K_STALL: return {16'b0, stall_cnt};
         default: return {31'b0, sb_err};
      endcase
   endfunction

   // A source is blocked if it has an outstanding write that is not arriving now.
   function automatic bit src_blocked(bit use_it, int s);
      if (!use_it || s == 0 || !m_pend[s]) return 1'b0;
      if (wb_valid && int'(wb_addr) == s) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_ready();
      int d;
      d = int'(issue_rd);
      if (reset || flush) return 1'b0;
      if (src_blocked(issue_use1, int'(issue_rs1))) return 1'b0;
      if (src_blocked(issue_use2, int'(issue_rs2))) return 1'b0;
      if (issue_wr && d != 0 && m_pend[d] && !(wb_valid && int'(wb_addr) == d)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_read(int a);
      if (a == 0) return 32'h0;
      if (wb_valid && int'(wb_addr) == a) return wb_data;
      return m_reg[a];
   endfunction

   function automatic logic [31:0] m_pend_vec();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NREGS; i++) if (m_pend[i]) v = v | (32'h1 << i);
      return v;
   endfunction

   task automatic m_update(bit rdy);
      int w, d;
      w = int'(wb_addr);
      d = int'(issue_rd);
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = (i == 2) ? SP : 32'h0;
            m_pend[i] = 1'b0;
         end
         m_err = 1'b0;
         m_stall = 0;
         return;
      end
      if (issue_valid && !rdy && m_stall < 65535) m_stall++;
      if (wb_valid && w != 0 && !m_pend[w] && !flush) m_err = 1'b1;
      if (wb_valid && w != 0) m_reg[w] = wb_data;
      if (flush) begin
         for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
      end else begin
         if (wb_valid && w != 0) m_pend[w] = 1'b0;
         if (issue_valid && rdy && issue_wr && d != 0) m_pend[d] = 1'b1;
      end
   endtask

   task automatic push(int k, logic [31:0] e);
      chk_t c;
      c.cyc = cyc_count;
      c.kind = k;
      c.exp = e;
      q.push_back(c);
   endtask

   // One clock: queue expectations for the present inputs, then advance.
   task automatic step();
      bit rdy;
      rdy = m_ready();
      if (chk_on) begin
         push(K_RD0, m_read(int'(rd_addr[AW-1:0])));
         push(K_RD1, m_read(int'(rd_addr[2*AW-1:AW])));
         push(K_RDY, {31'b0, rdy});
         push(K_PEND, m_pend_vec());
         push(K_STALL, m_stall[31:0]);
         push(K_ERR, {31'b0, m_err});
      end
      @(posedge soc_clk);
      m_update(rdy);
      #1;
      cyc_count++;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_wr = 1'b0; issue_use1 = 1'b0; issue_use2 = 1'b0;
      issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
   endtask

   task automatic set_issue(bit wr, int rd, bit u1, int rs1, bit u2, int rs2);
      issue_valid = 1'b1; issue_wr = wr; issue_rd = AW'(rd);
      issue_use1 = u1; issue_rs1 = AW'(rs1); issue_use2 = u2; issue_rs2 = AW'(rs2);
   endtask

   task automatic set_wb(int a, logic [31:0] d);
      wb_valid = 1'b1; wb_addr = AW'(a); wb_data = d;
   endtask

   task automatic set_rd(int a0, int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   // Monitor: compares every expectation queued for the current cycle.
   always @(negedge soc_clk) begin
      chk_t c;
      logic [31:0] a;
      while (q.size() > 0 && q[0].cyc <= cyc_count) begin
         c = q.pop_front();
         a = actual(c.kind);
         n_tests++;
         if (c.cyc != cyc_count) begin
            n_fail++;
            $display("FAIL stale_%s cycle %0d checked at %0d", kname(c.kind), c.cyc, cyc_count);
         end else if (a !== c.exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d got %h expected %h", kname(c.kind), c.cyc, a, c.exp);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc_count);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1;
      @(posedge soc_clk);
      #1;
      step();
      chk_on = 1'b1;
      step();
      reset = 1'b0;

      // Reset state: reads of 0, 2, 5 and idle ready
      set_rd(0, 2); step();
      set_rd(5, 2); step();

      // RAW stall on 5, released by a bypassed writeback
      set_issue(1, 5, 0, 0, 0, 0); step();
      set_issue(0, 0, 1, 5, 0, 0); set_rd(5, 0);
      for (int i = 0; i < 3; i++) step();
      set_wb(5, 32'hDEAD_BEEF); step();
      idle(); step();

      // Issue 7, then writeback 7 together with a second issue of 7
      set_issue(1, 7, 0, 0, 0, 0); step();
      set_wb(7, 32'h1234_5678); set_rd(7, 5); step();
      idle(); step();

      // Unmatched writeback to 9 sets sb_err; writeback to 0 is dropped
      set_wb(9, 32'hCAFE_0009); set_rd(9, 0); step();
      set_wb(0, 32'hFFFF_FFFF); set_rd(0, 9); step();
      idle(); step(); step();

      // Pending 3, 4, 6 then flush
      set_issue(1, 3, 0, 0, 0, 0); step();
      set_issue(1, 4, 0, 0, 0, 0); step();
      set_issue(1, 6, 0, 0, 0, 0); step();
      set_issue(1, 8, 0, 0, 0, 0); flush = 1'b1; step();
      idle(); set_rd(7, 9); step();
      set_rd(5, 2); step();

      // Long stall to saturate stall_cnt, then reset mid-stall
      set_issue(1, 10, 0, 0, 0, 0); step();
      set_issue(0, 0, 1, 10, 1, 10);
      for (int i = 0; i < 70000; i++) step();
      reset = 1'b1; step();
      reset = 1'b0; set_rd(2, 10); step();
      idle(); step();

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         idle();
         if ($urandom_range(0, 1) == 1)
            set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 31),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) set_wb($urandom_range(0, 31), $urandom);
         flush = ($urandom_range(0, 49) == 0);
         reset = ($urandom_range(0, 499) == 0);
         set_rd($urandom_range(0, 31), $urandom_range(0, 31));
         step();
      end
      reset = 1'b0;
      idle();
      step();

      @(negedge soc_clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
